uart_frame_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` serial emitter between `N_REQ` byte-stream requesters, such as sensor-timing and status producers. Each granted requester sends one whole frame without interleaving. The arbiter sequences the emitter's start/ready handshake, prefixes each frame with a header byte identifying the source, and enforces a maximum payload length. It sits between the producers and the single `uart_tx` instance that drives the board's serial line.

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_pick.sv | 36 +++
 rtl/uart_frame_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_frame_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, header tag default and
// the baud divisor used by uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_DONE,
    ST_FETCH
  } arb_state_t;

  localparam logic [3:0]  HDR_TAG_DEFAULT = 4'hA;
  localparam int unsigned CLK_HZ          = 12_000_000;
  localparam int unsigned B115200         = CLK_HZ / 115_200;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_ptr,
// wrapping to the lowest valid index when none is found above it.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [3:0]       rr_ptr,
  output logic [3:0]       grant,
  output logic             any
);

  logic       hi_found;
  logic       lo_found;
  logic [3:0] hi_idx;
  logic [3:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = 4'(i);
      end
      if (req_valid[i] && !hi_found && (32'(rr_ptr) <= i)) begin
        hi_found = 1'b1;
        hi_idx   = 4'(i);
      end
    end
    any   = lo_found;
    grant = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Round-robin frame arbiter sharing one uart_tx among N_REQ byte streams;
// each frame is a source header byte followed by up to MAX_LEN payload bytes.
module uart_frame_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter logic [3:0]  HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [3:0]         grant_id,
  output logic               busy,
  output logic               frame_err
);

  arb_state_t state;
  logic [3:0] rr_ptr;
  logic [7:0] len_cnt;
  logic       hdr_flag;
  logic       eof_flag;

  logic [3:0] pick_idx;
  logic       pick_any;
  logic       cur_valid;
  logic       cur_last;
  logic [7:0] cur_data;
  logic       len_hit;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == 4'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[8*i +: 8];
        if (state == ST_FETCH)
          req_ready[i] = req_valid[i];
      end
    end
  end

  assign len_hit = (len_cnt + 8'd1) == 8'(MAX_LEN);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      len_cnt   <= '0;
      hdr_flag  <= 1'b0;
      eof_flag  <= 1'b0;
      grant_id  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            tx_data  <= {HDR_TAG, pick_idx};
            hdr_flag <= 1'b1;
            eof_flag <= 1'b0;
            len_cnt  <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          tx_start <= 1'b0;
          if (!tx_ready)
            state <= ST_DONE;
        end
        ST_DONE: begin
          if (tx_ready) begin
            if (!hdr_flag && eof_flag) begin
              rr_ptr <= (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 4'd1;
              state  <= ST_IDLE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // A truncated frame leaves the requester's remaining bytes queued;
          // they open a fresh frame on its next grant.
          if (cur_valid) begin
            tx_data   <= cur_data;
            len_cnt   <= len_cnt + 8'd1;
            hdr_flag  <= 1'b0;
            eof_flag  <= cur_last | len_hit;
            frame_err <= len_hit & ~cur_last;
            state     <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter with a behavioural uart_tx emitter
// and per-requester byte queues.
module tb_uart_frame_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned ML = 2;

  logic           clk  = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b1;
  logic [3:0]     grant_id;
  logic           busy;
  logic           frame_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [8:0]  rq [N][$];
  logic [7:0]  sb [$];
  logic [N-1:0] take = '0;
  int unsigned pops      [N];
  int unsigned stall_req [N];
  int unsigned stall_cnt [N];
  int unsigned nstarts   = 0;
  int unsigned ferr_cnt  = 0;
  int unsigned hold      = 0;
  int unsigned hold_bad  = 0;
  int unsigned cyc       = 0;
  int unsigned ecnt      = 0;
  int unsigned start_cyc = 0;
  logic [7:0]  cap       = '0;

  uart_frame_arbiter #(.N_REQ(N), .MAX_LEN(ML), .HDR_TAG(4'hA)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_bytes(input logic [7:0] b[$]);
    foreach (b[k]) sb.push_back(b[k]);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_tx_start"},  32'(tx_start),  32'd0);
    chk({tag, "_tx_data"},   32'(tx_data),   32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_grant_id"},  32'(grant_id),  32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    bit done = 0;
    for (int unsigned c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #2;
      done = !busy && tx_ready && (sb.size() == 0);
      for (int i = 0; i < N; i++)
        if (rq[i].size() != 0) done = 0;
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_sb_left"},  sb.size(), 32'd0);
  endtask

  task automatic wait_start(input string tag, input int unsigned s0, input int unsigned budget);
    bit seen = 0;
    for (int unsigned c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = (nstarts != s0);
    end
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    take = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    hold_bad = 0;
    @(posedge clk);
    #2;
  endtask

  // Requester model: present queue heads, pop on the cycle after a handshake.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (take[i]) begin
          void'(rq[i].pop_front());
          pops[i]++;
          if (stall_req[i] > 0) begin
            stall_cnt[i] = stall_req[i];
            stall_req[i] = 0;
          end
        end
        if (stall_cnt[i] > 0) stall_cnt[i]--;
        if (rq[i].size() != 0 && stall_cnt[i] == 0) begin
          logic [8:0] h;
          h = rq[i][0];
          req_valid[i]       = 1'b1;
          req_last[i]        = h[8];
          req_data[8*i +: 8] = h[7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
      take = '0;
      #1;
      take = req_ready;
    end
  end

  // Emitter model: ready drops on tx_start, stays low 4 cycles, then rises.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_err) ferr_cnt++;
      if (tx_start) begin
        nstarts++;
        start_cyc = cyc;
        chk("start_when_ready", 32'(tx_ready), 32'd1);
        if (sb.size() == 0) chk("tx_byte_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        else                chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
        cap      = tx_data;
        ecnt     = 4;
        tx_ready = 1'b0;
      end else if (ecnt > 0) begin
        if (tx_data !== cap) hold_bad++;
        ecnt--;
        if (ecnt == 0) tx_ready = 1'b1;
      end else if (hold > 0) begin
        tx_ready = 1'b0;
        hold--;
        if (hold == 0) tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned s0, p0, f0, t0;
    for (int i = 0; i < N; i++) begin
      pops[i] = 0; stall_req[i] = 0; stall_cnt[i] = 0;
    end

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #2;

    // single requester, two-byte frame
    s0 = nstarts; p0 = pops[2];
    send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b1);
    expect_bytes('{8'hA2, 8'h11, 8'h22});
    wait_idle("single", 200);
    chk("single_pops",   pops[2] - p0, 32'd2);
    chk("single_starts", nstarts - s0, 32'd3);
    chk("single_busy",   32'(busy),    32'd0);

    // simultaneous requests from reset, then fairness
    do_reset();
    send(0, 8'h50, 1'b1); send(3, 8'h53, 1'b1);
    expect_bytes('{8'hA0, 8'h50, 8'hA3, 8'h53});
    wait_idle("simul", 300);
    send(0, 8'h60, 1'b1);
    expect_bytes('{8'hA0, 8'h60});
    wait_idle("rerequest", 200);
    send(0, 8'h70, 1'b1); send(0, 8'h71, 1'b1); send(3, 8'h73, 1'b1);
    expect_bytes('{8'hA3, 8'h73, 8'hA0, 8'h70, 8'hA0, 8'h71});
    wait_idle("fair", 400);

    // truncation at MAX_LEN=2
    f0 = ferr_cnt;
    send(1, 8'h01, 1'b0); send(1, 8'h02, 1'b0); send(1, 8'h03, 1'b1);
    expect_bytes('{8'hA1, 8'h01, 8'h02, 8'hA1, 8'h03});
    wait_idle("trunc", 400);
    chk("trunc_frame_err", ferr_cnt - f0, 32'd1);

    // requester stall mid-frame while another requester waits
    p0 = pops[0];
    stall_req[0] = 50;
    send(0, 8'hB1, 1'b0); send(0, 8'hB2, 1'b1); send(1, 8'hC1, 1'b1);
    expect_bytes('{8'hA0, 8'hB1, 8'hB2, 8'hA1, 8'hC1});
    for (int unsigned c = 0; c < 100 && pops[0] == p0; c++) @(negedge clk);
    chk("stall_first_pop", pops[0] - p0, 32'd1);
    repeat (10) @(negedge clk);
    s0 = nstarts;
    repeat (30) @(negedge clk);
    #1;
    chk("stall_no_start", nstarts - s0,  32'd0);
    chk("stall_grant",    32'(grant_id), 32'd0);
    chk("stall_busy",     32'(busy),     32'd1);
    wait_idle("stall", 400);

    // emitter held busy at frame start
    s0 = nstarts; t0 = cyc;
    hold = 100;
    send(2, 8'h33, 1'b1);
    expect_bytes('{8'hA2, 8'h33});
    wait_start("hold", s0, 400);
    chk("hold_delay", 32'((start_cyc - t0) >= 100), 32'd1);
    wait_idle("hold", 200);
    chk("hold_starts",     nstarts - s0, 32'd2);
    chk("tx_data_stable",  hold_bad,     32'd0);

    // reset while the header byte is in flight
    s0 = nstarts;
    send(3, 8'hD1, 1'b0); send(3, 8'hD2, 1'b1);
    expect_bytes('{8'hA3, 8'hD1, 8'hD2});
    wait_start("midrst", s0, 100);
    rstn = 1'b0;
    #1;
    chk_rst("midrst");
    do_reset();
    send(1, 8'hE1, 1'b1);
    expect_bytes('{8'hA1, 8'hE1});
    wait_idle("after_rst", 200);
    chk("after_rst_stable", hold_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
